// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and stage-register layout for pipelined_adder
package adder_pkg;

   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_STAGES = 4;
   localparam int MAX_WIDTH      = 64;

   // Fields are sized for the widest legal operand; narrower builds use the low bits.
   typedef struct packed {
      logic                 valid;
      logic                 mode;
      logic                 carry;
      logic [MAX_WIDTH-1:0] a_rem;
      logic [MAX_WIDTH-1:0] b_rem;
      logic [MAX_WIDTH-1:0] sum_done;
   } stage_t;

endpackage

// File: rtl/adder_nbit.sv
// rtl/adder_nbit.sv - one chunk of ripple addition with carry into its top bit exposed
module adder_nbit #(
   parameter int BITS = 4
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            carry_in,
   output logic [BITS-1:0] sum,
   output logic            carry_out,
   output logic            carry_msb_in
);

   always_comb begin
      {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, carry_in};
      // The sum bit is a ^ b ^ carry, so the carry into the MSB falls out directly.
      carry_msb_in = a[BITS-1] ^ b[BITS-1] ^ sum[BITS-1];
   end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked add/subtract pipeline with valid/ready flow control
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CHUNK = WIDTH / STAGES;

   logic                 stall;
   logic                 ovf_q;
   logic [MAX_WIDTH-1:0] a_ext;
   logic [MAX_WIDTH-1:0] b_ext;

   assign a_ext    = MAX_WIDTH'(a);
   assign b_ext    = MAX_WIDTH'(b);
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t               q;
      logic                 vin;
      logic                 md;
      logic                 cc;
      logic [MAX_WIDTH-1:0] ar;
      logic [MAX_WIDTH-1:0] br;
      logic [MAX_WIDTH-1:0] sd;
      logic [CHUNK-1:0]     ca;
      logic [CHUNK-1:0]     cb;
      logic [CHUNK-1:0]     cs;
      logic                 cco;
      logic                 cmsb;

      if (k == 0) begin : g_first
         // Subtract is a + ~b + ~borrow; the inversion of b happens per chunk.
         assign vin = in_valid;
         assign md  = mode;
         assign cc  = carry_in ^ mode;
         assign ar  = a_ext;
         assign br  = b_ext;
         assign sd  = '0;
      end else begin : g_next
         assign vin = g_stage[k-1].q.valid;
         assign md  = g_stage[k-1].q.mode;
         assign cc  = g_stage[k-1].q.carry;
         assign ar  = g_stage[k-1].q.a_rem;
         assign br  = g_stage[k-1].q.b_rem;
         assign sd  = g_stage[k-1].q.sum_done;
      end

      assign ca = ar[CHUNK-1:0];
      assign cb = br[CHUNK-1:0] ^ {CHUNK{md}};

      adder_nbit #(.BITS(CHUNK)) u_add (
         .a            (ca),
         .b            (cb),
         .carry_in     (cc),
         .sum          (cs),
         .carry_out    (cco),
         .carry_msb_in (cmsb)
      );

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            q <= '0;
         end else if (!stall) begin
            q.valid    <= vin;
            q.mode     <= md;
            q.carry    <= cco;
            q.a_rem    <= ar >> CHUNK;
            q.b_rem    <= br >> CHUNK;
            q.sum_done <= sd | (MAX_WIDTH'(cs) << (k * CHUNK));
         end
      end

      if (k == STAGES - 1) begin : g_last
         logic unused_last;
         assign unused_last = ^{cmsb, q.mode, q.a_rem, q.b_rem, q.sum_done};

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               ovf_q <= 1'b0;
            end else if (!stall) begin
               ovf_q <= cmsb ^ cco;
            end
         end
      end else begin : g_mid
         logic unused_msb;
         assign unused_msb = cmsb;
      end
   end

   assign out_valid = g_stage[STAGES-1].q.valid;
   assign sum       = g_stage[STAGES-1].q.sum_done[WIDTH-1:0];
   assign carry_out = g_stage[STAGES-1].q.carry;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4)
module tb_pipelined_adder;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [15:0] a, b;
   logic        carry_in, mode, in_valid, in_ready;
   logic [15:0] sum;
   logic        carry_out, overflow, out_valid;
   logic        out_ready = 1'b1;

   pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
      int          tag;
      bit          lat;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        md;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stall_from = -1;
   int   stall_to = -1;
   bit   rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      else          out_ready = !(cyc >= stall_from && cyc <= stall_to);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                                 input logic md, output logic [15:0] s, output logic co,
                                 output logic ov);
      int r, sr;
      if (!md) begin
         r  = int'(av) + int'(bv) + int'(ci);
         sr = int'($signed(av)) + int'($signed(bv)) + int'(ci);
         co = (r > 65535);
      end else begin
         r  = int'(av) - int'(bv) - int'(ci);
         sr = int'($signed(av)) - int'($signed(bv)) - int'(ci);
         co = (r >= 0);
      end
      s  = r[15:0];
      ov = (sr > 32767) || (sr < -32768);
   endfunction

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic md,
                       input logic [15:0] es, input logic eco, input logic eov, input bit lat);
      exp_t e;
      int   guard = 0;
      @(posedge clk);
      #1;
      a = av; b = bv; carry_in = ci; mode = md; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout actual=in_ready_low required=accept_within_200");
      end else begin
         e.s = es; e.co = eco; e.ov = eov; e.tag = cyc; e.lat = lat;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
      carry_in = 1'($urandom); mode = 1'($urandom);
      repeat (n - 1) @(posedge clk);
   endtask

   // Monitor: pops the scoreboard whenever a result transfers out.
   logic        held_v = 1'b0;
   logic [15:0] held_s;
   logic        held_co, held_ov;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (n_rst) begin
            chk("in_ready_vs_stall", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (held_v) chk("hold_outputs", {14'd0, out_valid, carry_out, overflow, sum},
                            {14'd0, 1'b1, held_co, held_ov, held_s});
            held_v = out_valid && !out_ready;
            held_s = sum; held_co = carry_out; held_ov = overflow;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_result actual=sum_%0h required=no_output", sum);
               end else begin
                  e = sb.pop_front();
                  chk("sum", {16'd0, sum}, {16'd0, e.s});
                  chk("carry_out", {31'd0, carry_out}, {31'd0, e.co});
                  chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                  if (e.lat) chk("latency", cyc - e.tag, 32'd4);
               end
            end
         end else begin
            held_v = 1'b0;
         end
      end
   end

   initial begin
      logic [15:0] ra, rb, es;
      logic        rc, rm, eco, eov;
      int          base, guard;

      vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
      vecs[10] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[11] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};

      n_rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; mode = 1'b0;
      #12;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_sum", {16'd0, sum}, 32'd0);
      chk("reset_carry_overflow", {30'd0, carry_out, overflow}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      n_rst = 1'b1;

      // Lone op first, then all directed vectors back to back.
      send(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].md, vecs[0].s, vecs[0].co, vecs[0].ov, 1'b1);
      idle(8);
      for (int i = 0; i < 12; i++)
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].md, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b1);
      idle(10);

      // Eight back-to-back ops with the sink stalled for cycles 5-7.
      base = cyc; stall_from = base + 5; stall_to = base + 7;
      for (int i = 0; i < 8; i++)
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].md, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0);
      idle(14);
      stall_from = -1; stall_to = -1;
      chk("stall_drained", sb.size(), 32'd0);

      // Reset with three ops in flight: they must vanish.
      for (int i = 0; i < 3; i++)
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].md, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
      sb.delete();
      @(negedge clk);
      n_rst = 1'b1;
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
      idle(10);
      send(vecs[3].a, vecs[3].b, vecs[3].cin, vecs[3].md, vecs[3].s, vecs[3].co, vecs[3].ov, 1'b1);
      idle(8);
      chk("post_reset_drained", sb.size(), 32'd0);

      // Random operands with random bubbles and random back-pressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rm = 1'($urandom);
         model(ra, rb, rc, rm, es, eco, eov);
         send(ra, rb, rc, rm, es, eco, eov, 1'b0);
      end
      idle(1);
      rand_rdy = 1'b0;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      chk("final_drained", sb.size(), 32'd0);
      repeat (4) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/sum width in bits (legal 4..64).
REQ-002 The block SHALL have parameter STAGES, default 4, pipeline depth; WIDTH mod STAGES SHALL be 0; CHUNK = WIDTH/STAGES.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-006 b  input  WIDTH  operand B.
REQ-007 carry_in  input  1  carry (add) or borrow (subtract) into bit 0.
REQ-008 mode  input  1  0 = add, 1 = subtract.
REQ-009 in_valid  input  1  operands valid this cycle.
REQ-010 in_ready  output  1  block accepts operands this cycle.
REQ-011 sum  output  WIDTH  result.
REQ-012 carry_out  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-013 overflow  output  1  signed two's-complement overflow.
REQ-014 out_valid  output  1  result outputs valid.
REQ-015 out_ready  input  1  downstream accepts result.

Function
REQ-016 Add SHALL compute {carry_out,sum} = a + b + carry_in, modulo 2^(WIDTH+1).
REQ-017 Subtract SHALL compute a + ~b + (~carry_in), i.e. a - b - carry_in, carry_out = final carry.
REQ-018 overflow SHALL be 1 iff the carries into and out of bit WIDTH-1 differ.
REQ-019 Stage k (0..STAGES-1) SHALL add chunk k only, using carry registered from stage k-1; unprocessed upper chunks and finished lower sum chunks SHALL be carried forward in stage registers.
REQ-020 Transfer in SHALL occur on a rising edge with in_valid=1 and in_ready=1; transfer out with out_valid=1 and out_ready=1.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, absent stalls.
REQ-022 stall = out_valid & ~out_ready; in_ready SHALL equal ~stall (combinational).
REQ-023 During stall every stage register including valid bits SHALL hold; no bubble compression.
REQ-024 Without stall, throughput SHALL be one operation per cycle; invalid slots propagate as bubbles.
REQ-025 sum/carry_out/overflow SHALL be registered outputs, stable while out_valid=1 and stalled.
REQ-026 Inputs presented with in_valid=0 or in_ready=0 SHALL not affect any result.
REQ-027 mode and carry_in SHALL be captured with operands and travel with them per stage.

Reset
REQ-028 n_rst=0 SHALL asynchronously clear all stage valid bits, sum=0, carry_out=0, overflow=0, out_valid=0.
REQ-029 Reset mid-operation SHALL discard all in-flight results; no result SHALL emerge after release.
REQ-030 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-031 A shared package adder_pkg SHALL hold the default WIDTH/STAGES constants and a stage-register struct typedef (valid, mode, carry, a_rem, b_rem, sum_done).
REQ-032 Per-chunk arithmetic SHALL be a sub-module adder_nbit (parameter BITS; a, b, carry_in -> sum, carry_out, carry_msb_in), instantiated STAGES times via generate.

Verification (WIDTH=16, STAGES=4)
REQ-033 Add 0xFFFF+0x0001, cin=0 -> after 4 cycles sum=0x0000, carry_out=1, overflow=0, out_valid=1 for one cycle.
REQ-034 Add 0x7FFF+0x0001, cin=0 -> sum=0x8000, carry_out=0, overflow=1.
REQ-035 Subtract 0x0005-0x0007, cin=0 -> sum=0xFFFE, carry_out=0, overflow=0; subtract 0x8000-0x0001 -> sum=0x7FFF, carry_out=1, overflow=1.
REQ-036 Back-to-back 8 ops with out_ready=0 for cycles 5-7 -> in_ready=0 those cycles, outputs held, all 8 results delivered in order, none lost or duplicated.
REQ-037 Assert n_rst=0 with 3 ops in flight -> out_valid=0 immediately, no result after release, next op correct at 4-cycle latency.
REQ-038 Random 10000 ops with random in_valid/out_ready against a+b+cin / a-b-cin reference model -> zero mismatches.
